// File: rtl/dct_pkg.sv
// dct_pkg: shared state encoding and count comparison helper for the down-count timer
package dct_pkg;
  localparam int CMP_W = 32;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN = 1'b1;
  typedef enum logic {IDLE = ST_IDLE, RUN = ST_RUN} state_e;
  function automatic logic cnt_eq(input logic [CMP_W-1:0] v, input logic [CMP_W-1:0] k);
    return v == k;
  endfunction
endpackage

// File: rtl/down_count_reg.sv
// down_count_reg: WIDTH-bit count register with synchronous clear, load and decrement
module down_count_reg
  import dct_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec_en,
  output logic [WIDTH-1:0] q,
  output logic             is_one
);
  logic [WIDTH-1:0] q_q, q_d;
  always_comb q_d = load_en ? load_value : dec_en ? q_q - 1'b1 : q_q;
  always_ff @(posedge clock) q_q <= clear ? '0 : q_d;
  assign q = q_q;
  assign is_one = cnt_eq(CMP_W'(q_q), CMP_W'(1));
endmodule

// File: rtl/down_count_timer.sv
// down_count_timer: loadable down counter with pause, abort, auto-reload and done pulse
module down_count_timer
  import dct_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d, ld_val;
  logic done_q, done_d, ld_en, dec_en, is_one, q_zero;
  down_count_reg #(.WIDTH(WIDTH)) u_cnt (
    .clock(clock), .clear(clear), .load_en(ld_en), .load_value(ld_val),
    .dec_en(dec_en), .q(q), .is_one(is_one)
  );
  assign q_zero = cnt_eq(CMP_W'(q), CMP_W'(0));
  // RUN only ever holds q==0 during the reload step after an auto-reload expiry
  always_comb begin
    state_d = state_q;
    reload_d = reload_q;
    done_d = 1'b0;
    ld_en = 1'b0;
    ld_val = load_value;
    dec_en = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (load_en) begin
        reload_d = load_value;
        ld_en = 1'b1;
        state_d = (start && load_value != '0) ? RUN : IDLE;
        done_d = start && load_value == '0;
      end else if (start) begin
        state_d = q_zero ? IDLE : RUN;
        done_d = q_zero;
      end
    end else if (!pause) begin
      if (q_zero) begin
        ld_en = 1'b1;
        ld_val = reload_q;
      end else begin
        dec_en = 1'b1;
        done_d = is_one;
        state_d = (is_one && !(auto_reload && reload_q != '0)) ? IDLE : RUN;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      reload_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      reload_q <= reload_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = done_q;
endmodule

// File: doc/down_count_timer.md
Name: down_count_timer

Overview:
- Synchronous, loadable WIDTH-bit down counter/timer.
- Companion to the 4-bit ripple up counter: counts in the opposite direction, fully synchronous.
- Counts a programmed value down to zero and raises a one-cycle done pulse.
- Supports pause, abort and auto-reload.
- Used as a programmable delay/interval generator beside the up counters in the same clock domain.

Parameters:
- WIDTH, 4, counter and load-value width in bits (WIDTH >= 2).

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- clear  input  1  synchronous, active-high reset; sampled on rising edge of clock.
- load_en  input  1  load load_value into reload register and counter.
- load_value  input  WIDTH  value to load.
- start  input  1  begin counting (pulse or level; acted on only in IDLE).
- pause  input  1  level; freezes count while RUN.
- stop  input  1  abort; return to IDLE, q retained.
- auto_reload  input  1  level; on expiry, reload and keep running.
- q  output  WIDTH  current count.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse, coincident with the cycle q first shows 0 after a countdown.

Behaviour:
- States: IDLE, RUN. All outputs are registered.
- Reset (clear=1 at edge): q=0, reload_reg=0, state=IDLE, busy=0, done=0. clear dominates every other input, including mid-count.
- Priority at each edge, after clear: stop > load_en > start > count.
- stop=1: state->IDLE, q held, done=0. Same-cycle load_en/start ignored.
- load_en=1 in IDLE:
  - reload_reg<=load_value, q<=load_value.
  - If start=1 in the same cycle, also state->RUN (or done pulse only, if load_value=0).
- load_en=1 in RUN: ignored entirely; q and reload_reg unchanged.
- start=1 in IDLE, q!=0: state->RUN, busy=1 from the next cycle; q unchanged on that edge.
- start=1 in IDLE, q=0: stay IDLE, done=1 for one cycle.
- start in RUN: ignored.
- RUN, pause=1: q held, busy stays 1, done=0.
- RUN, pause=0, q>1: q<=q-1.
- RUN, pause=0, q=1:
  - q<=0 and done<=1 (one cycle).
  - auto_reload=0: state->IDLE, busy<=0.
  - auto_reload=1 and reload_reg!=0: stay RUN; the next unpaused edge loads q<=reload_reg (no decrement that edge). Period is therefore reload_reg+1 cycles.
  - auto_reload=1 and reload_reg=0: state->IDLE.
- Reload step with pause=1: held until pause drops.
- done is never asserted for two consecutive cycles except via start in IDLE with q=0 held high.
- Latency: load 3 + start at edge E0 -> q=3 after E0, 2 after E1, 1 after E2, 0 with done=1 after E3. N cycles from start to done for load value N.
- Arithmetic: modulo-2^WIDTH unsigned. RUN never decrements from 0, so q never wraps to all-ones.
- Max load (2^WIDTH-1) must count fully: 15 -> 0 in 15 cycles for WIDTH=4.

Decomposition:
- Shared package dct_pkg:
  - state typedef {IDLE, RUN}.
  - Localparams for state encoding.
  - Function for the zero/one comparisons, parameterised by WIDTH.
- One natural sub-module, down_count_reg:
  - WIDTH-bit register with synchronous clear, load, and decrement enable.
  - Outputs q and is_one.
  - Top level holds the FSM, reload_reg and done/busy logic.

Test Plan:
- Reset: drive random inputs with clear=1 for 2 cycles -> q=0, busy=0, done=0; assert clear mid-count (q=5) -> next cycle q=0, IDLE.
- Basic count, WIDTH=4: load 3 + start same cycle -> q sequence 3,2,1,0; done=1 only in the q=0 cycle; busy falls with done.
- Pause: load 6, start, pause=1 for 4 cycles when q=4 -> q stays 4, busy=1, no done; resume -> 3,2,1,0, done total latency 10 cycles.
- Auto-reload: load 2, auto_reload=1, start -> q 2,1,0,2,1,0,...; done every 3 cycles; drop auto_reload -> ends IDLE after next done.
- Boundaries:
  - load 0 + start -> done pulse next cycle, busy never 1.
  - load 15 -> 15 decrements to 0, no wrap to 15.
- Priority: in RUN at q=5, assert stop+load_en(9)+start -> IDLE, q=5, reload_reg unchanged; then load_en in RUN ignored (q keeps counting).
